// File: rtl/retire_stream_checker.sv
// Stream-level consistency checker for the per-cycle retirement record.
// Flags order/PC/x0/memory/timeout/post-halt faults and tracks halt.
module retire_stream_checker #(
    parameter logic [31:0] START_PC = 32'h1eceb000,
    parameter int          TIMEOUT  = 10000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [63:0]      order,
    input  logic             halt,
    input  logic [4:0]       rd_addr,
    input  logic [31:0]      rd_wdata,
    input  logic [31:0]      pc_rdata,
    input  logic [31:0]      pc_wdata,
    input  logic [31:0]      mem_addr,
    input  logic [3:0]       mem_rmask,
    input  logic [3:0]       mem_wmask,
    output logic             error,
    output logic [2:0]       error_code,
    output logic [63:0]      error_order,
    output logic             halted,
    output logic [63:0]      commit_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ORDER    = 3'd1;
    localparam logic [2:0] ERR_PC       = 3'd2;
    localparam logic [2:0] ERR_X0       = 3'd3;
    localparam logic [2:0] ERR_MEM      = 3'd4;
    localparam logic [2:0] ERR_ALIGN    = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;
    localparam logic [2:0] ERR_POSTHALT = 3'd7;

    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nx;
    logic [63:0]       exp_order;
    logic [31:0]       exp_pc;
    logic [CNT_W-1:0]  watchdog;
    logic [CNT_W-1:0]  watchdog_inc;

    logic              active;
    logic              mem_any;
    logic [2:0]        rec_code;
    logic [2:0]        fail_code;
    logic [63:0]       fail_order;
    logic              timeout_hit;
    logic              accept;

    assign active       = (state == S_IDLE) || (state == S_RUN);
    assign mem_any      = (mem_rmask | mem_wmask) != 4'd0;
    assign watchdog_inc = watchdog + 1'b1;
    assign timeout_hit  = active && !valid && (watchdog_inc == TO_CNT);

    // Record checks in priority order: the lowest failing code wins.
    always_comb begin
        rec_code = ERR_NONE;
        if (order != exp_order) begin
            rec_code = ERR_ORDER;
        end else if (pc_rdata != exp_pc) begin
            rec_code = ERR_PC;
        end else if (rd_addr == 5'd0 && rd_wdata != 32'd0) begin
            rec_code = ERR_X0;
        end else if (mem_rmask != 4'd0 && mem_wmask != 4'd0) begin
            rec_code = ERR_MEM;
        end else if (mem_any && mem_addr[1:0] != 2'd0) begin
            rec_code = ERR_ALIGN;
        end
    end

    assign accept = active && valid && (rec_code == ERR_NONE);

    always_comb begin
        fail_code  = ERR_NONE;
        fail_order = 64'd0;
        if (active && valid && rec_code != ERR_NONE) begin
            fail_code  = rec_code;
            fail_order = order;
        end else if (timeout_hit) begin
            fail_code  = ERR_TIMEOUT;
        end else if (state == S_HALTED && valid) begin
            fail_code  = ERR_POSTHALT;
            fail_order = order;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_RUN: begin
                if (fail_code != ERR_NONE) begin
                    state_nx = S_ERROR;
                end else if (accept) begin
                    state_nx = halt ? S_HALTED : S_RUN;
                end
            end
            S_HALTED: begin
                if (fail_code != ERR_NONE) begin
                    state_nx = S_ERROR;
                end
            end
            S_ERROR: begin
                state_nx = S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_order    <= 64'd0;
            exp_pc       <= START_PC;
            commit_count <= 64'd0;
            halted       <= 1'b0;
        end else if (accept) begin
            exp_order    <= order + 64'd1;
            exp_pc       <= pc_wdata;
            commit_count <= commit_count + 64'd1;
            halted       <= halted | halt;
        end
    end

    // Only the first failure is recorded; ERROR is absorbing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error       <= 1'b0;
            error_code  <= ERR_NONE;
            error_order <= 64'd0;
        end else if (fail_code != ERR_NONE) begin
            error       <= 1'b1;
            error_code  <= fail_code;
            error_order <= fail_order;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            watchdog <= '0;
        end else if (valid) begin
            watchdog <= '0;
        end else if (active) begin
            watchdog <= watchdog_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (active && cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_retire_stream_checker.sv
// Bench for retire_stream_checker: spec-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_retire_stream_checker;

    localparam logic [31:0] SPC = 32'h1eceb000;
    localparam int          TO  = 8;
    localparam int          CW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic [63:0]   order = '0;
    logic          halt = 1'b0;
    logic [4:0]    rd_addr = '0;
    logic [31:0]   rd_wdata = '0;
    logic [31:0]   pc_rdata = '0;
    logic [31:0]   pc_wdata = '0;
    logic [31:0]   mem_addr = '0;
    logic [3:0]    mem_rmask = '0;
    logic [3:0]    mem_wmask = '0;
    logic          error;
    logic [2:0]    error_code;
    logic [63:0]   error_order;
    logic          halted;
    logic [63:0]   commit_count;
    logic [CW-1:0] cycle_count;

    retire_stream_checker #(
        .START_PC(SPC),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .order       (order),
        .halt        (halt),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .pc_rdata    (pc_rdata),
        .pc_wdata    (pc_wdata),
        .mem_addr    (mem_addr),
        .mem_rmask   (mem_rmask),
        .mem_wmask   (mem_wmask),
        .error       (error),
        .error_code  (error_code),
        .error_order (error_order),
        .halted      (halted),
        .commit_count(commit_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Spec-level model: what the outputs must read after each edge.
    bit          m_err = 0;
    bit          m_halt = 0;
    int          m_code = 0;
    bit [63:0]   m_eord = 0;
    bit [63:0]   m_commits = 0;
    bit [63:0]   m_exp_ord = 0;
    bit [31:0]   m_exp_pc = SPC;
    int          m_idle = 0;
    int          m_cyc = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_err = 0; m_halt = 0; m_code = 0; m_eord = 0;
            m_commits = 0; m_exp_ord = 0; m_exp_pc = SPC;
            m_idle = 0; m_cyc = 0;
        end else begin
            int c;
            if (!m_err && !m_halt && m_cyc < (1 << CW) - 1)
                m_cyc++;
            if (m_err) begin
                if (valid) m_idle = 0;
            end else if (m_halt) begin
                if (valid) begin
                    m_err = 1; m_code = 7; m_eord = order;
                end
            end else if (valid) begin
                m_idle = 0;
                c = 0;
                if (order != m_exp_ord) c = 1;
                else if (pc_rdata != m_exp_pc) c = 2;
                else if (rd_addr == 0 && rd_wdata != 0) c = 3;
                else if (mem_rmask != 0 && mem_wmask != 0) c = 4;
                else if ((mem_rmask | mem_wmask) != 0 && mem_addr % 4 != 0) c = 5;
                if (c != 0) begin
                    m_err = 1; m_code = c; m_eord = order;
                end else begin
                    m_commits++;
                    m_exp_ord = order + 1;
                    m_exp_pc = pc_wdata;
                    if (halt) m_halt = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_err = 1; m_code = 6; m_eord = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("error", 64'(error), 64'(m_err));
            chk("error_code", 64'(error_code), 64'(m_code));
            chk("error_order", error_order, m_eord);
            chk("halted", 64'(halted), 64'(m_halt));
            chk("commit_count", commit_count, m_commits);
            chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
        end
    end

    task automatic put(input logic [63:0] o, input logic [31:0] pc,
                       input logic h = 1'b0, input logic [4:0] rd = 5'd1,
                       input logic [31:0] wd = 32'd0,
                       input logic [31:0] a = 32'd0,
                       input logic [3:0] rm = 4'd0,
                       input logic [3:0] wm = 4'd0);
        @(negedge clk);
        valid = 1'b1; order = o; pc_rdata = pc; pc_wdata = pc + 32'd4;
        halt = h; rd_addr = rd; rd_wdata = wd; mem_addr = a;
        mem_rmask = rm; mem_wmask = wm;
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #12;
        cmp_en = 1'b1;
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_commit", commit_count, 64'd0);
        chk("rst_cycle", 64'(cycle_count), 64'd0);
        @(negedge clk);
        #1 rst = 1'b1;

        // five records, last one halts
        for (int i = 0; i < 5; i++)
            put(64'(i), SPC + 32'(4 * i), i == 4);
        idle();
        chk("t1_halted", 64'(halted), 64'd1);
        chk("t1_commit", commit_count, 64'd5);
        chk("t1_error", 64'(error), 64'd0);

        // valid after halt
        put(64'd5, SPC + 32'd20);
        idle();
        chk("t6_code", 64'(error_code), 64'd7);
        chk("t6_eorder", error_order, 64'd5);
        chk("t6_halted", 64'(halted), 64'd1);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_error", 64'(error), 64'd0);
        chk("async_halted", 64'(halted), 64'd0);
        chk("async_commit", commit_count, 64'd0);
        chk("async_code", 64'(error_code), 64'd0);
        @(negedge clk);
        #1 rst = 1'b1;

        // order gap
        put(64'd0, SPC);
        put(64'd1, SPC + 32'd4);
        put(64'd3, SPC + 32'd8);
        idle();
        chk("t2_code", 64'(error_code), 64'd1);
        chk("t2_eorder", error_order, 64'd3);
        chk("t2_commit", commit_count, 64'd2);
        put(64'd2, SPC + 32'd8);
        put(64'd3, SPC + 32'd12);
        idle();
        chk("t2_sticky_code", 64'(error_code), 64'd1);
        chk("t2_sticky_commit", commit_count, 64'd2);

        // PC and x0 faults together: PC wins
        do_reset();
        put(64'd0, SPC + 32'd4, 1'b0, 5'd0, 32'd5);
        idle();
        chk("t3_code", 64'(error_code), 64'd2);
        chk("t3_commit", commit_count, 64'd0);

        do_reset();
        put(64'd0, SPC, 1'b0, 5'd1, 32'd0, 32'h1000_0002, 4'hf, 4'h0);
        idle();
        chk("t4_align", 64'(error_code), 64'd5);

        do_reset();
        put(64'd0, SPC, 1'b0, 5'd1, 32'd0, 32'h0, 4'h1, 4'h1);
        idle();
        chk("t4_mem", 64'(error_code), 64'd4);

        // legal aligned accesses and x0 written with zero
        do_reset();
        put(64'd0, SPC, 1'b0, 5'd0, 32'd0, 32'h1000_0004, 4'hf, 4'h0);
        put(64'd1, SPC + 32'd4, 1'b0, 5'd2, 32'd9, 32'h8, 4'h0, 4'h3);
        idle();
        chk("legal_error", 64'(error), 64'd0);
        chk("legal_commit", commit_count, 64'd2);

        // watchdog: fires on the 8th idle cycle
        do_reset();
        put(64'd0, SPC);
        repeat (7) idle();
        @(negedge clk);
        chk("t5_before", 64'(error), 64'd0);
        @(negedge clk);
        chk("t5_error", 64'(error), 64'd1);
        chk("t5_code", 64'(error_code), 64'd6);
        chk("t5_eorder", error_order, 64'd0);

        // cycle counter saturation
        do_reset();
        for (int i = 0; i < 40; i++)
            put(64'(i), SPC + 32'(4 * i));
        idle();
        chk("sat_cycle", 64'(cycle_count), 64'd31);
        chk("sat_commit", commit_count, 64'd40);
        chk("sat_error", 64'(error), 64'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
